chunked_serial_adder: RTL

Parametrised multi-cycle adder/subtractor that processes a `WIDTH`-bit operation `CHUNK` bits per clock. A registered carry links the chunks, so wide adds run in narrow carry logic. It is the generalised, sequential successor of the fixed 4-bit combinational ripple adder. It adds carry-in, subtract mode, signed-overflow detection, and valid/ready handshakes on both the operand and result sides, so it can sit between streaming datapath stages.

---
 rtl/chunked_serial_adder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/chunked_serial_adder.sv
// Sequential adder/subtractor: processes a WIDTH-bit operation CHUNK bits per clock,
// linking chunks through a registered carry, with valid/ready on both sides.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] out_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic             start_ready_r;
  logic             out_valid_r;
  logic             accept_s;
  logic             last_s;
  logic [CHUNK:0]   sum_s;

  assign accept_s = start_valid && start_ready_r;
  assign last_s   = (cnt_r == CW'(NCHUNK - 1));

  // Operands shift right each RUN cycle, so the active chunk always sits in the low bits.
  always_comb begin
    sum_s = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + (CHUNK+1)'(carry_r);
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus registered handshake flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      start_ready_r <= 1'b1;
      out_valid_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      start_ready_r <= (state_s == IDLE);
      out_valid_r   <= (state_s == DONE);
    end
  end

  // Datapath: operand capture, per-chunk add, result assembly and final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      out_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= in1;
            b_r     <= sub ? ~in2 : in2;
            carry_r <= sub ? 1'b1 : cin;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          a_r     <= a_r >> CHUNK;
          b_r     <= b_r >> CHUNK;
          // Result chunks enter at the top and settle into place after the last chunk.
          out_r   <= (out_r >> CHUNK) | (WIDTH'(sum_s[CHUNK-1:0]) << (WIDTH - CHUNK));
          carry_r <= sum_s[CHUNK];
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            cout_r <= sum_s[CHUNK];
            ovf_r  <= (a_r[CHUNK-1] == b_r[CHUNK-1]) && (sum_s[CHUNK-1] != a_r[CHUNK-1]);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign start_ready = start_ready_r;
  assign out_valid   = out_valid_r;
  assign out         = out_r;
  assign cout        = cout_r;
  assign ovf         = ovf_r;

endmodule
